// File: rtl/seqmul_arbiter.sv
// Two-requester round-robin front end feeding a shift-add unsigned multiplier.
// One operation is in flight at a time. The result is held until the consumer
// takes it, and only then can the next request be accepted.
module seqmul_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    output logic                 req1_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_product,
    output logic                 busy
);

    // The counter has to reach WIDTH itself, because the DONE transition
    // spends one extra edge after the last iteration.
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplr;
    logic [WIDTH:0]   acc;
    logic [CW-1:0]    count;
    logic             last_served;
    logic             id_q;
    logic             valid_q;
    logic             grant0;
    logic             grant1;
    logic [WIDTH:0]   sum;

    // Grant is combinational in IDLE. On a tie it goes to the requester not
    // served last. Both grants are held low while reset is asserted.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && reset) begin
            if (req0_valid && req1_valid) begin
                grant0 = last_served;
                grant1 = ~last_served;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    // Conditional add for one iteration. The carry bit of acc is always 0 at
    // this point because the previous shift cleared it.
    always_comb begin
        sum = acc;
        if (mplr[0]) begin
            sum = acc + {1'b0, mcand};
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign rsp_valid   = valid_q;
    assign rsp_id      = id_q;
    assign rsp_product = {acc[WIDTH-1:0], mplr};
    assign busy        = (state != IDLE);

    // Control FSM and datapath. The product is built in {acc, mplr}, which
    // shifts right as a single register on each iteration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            mcand       <= '0;
            mplr        <= '0;
            acc         <= '0;
            count       <= '0;
            last_served <= 1'b1;
            id_q        <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        mcand       <= grant1 ? req1_a : req0_a;
                        mplr        <= grant1 ? req1_b : req0_b;
                        acc         <= '0;
                        count       <= '0;
                        id_q        <= grant1;
                        last_served <= grant1;
                        state       <= CALC;
                    end
                end
                CALC: begin
                    if (count == CW'(WIDTH)) begin
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        acc   <= {1'b0, sum[WIDTH:1]};
                        mplr  <= {sum[0], mplr[WIDTH-1:1]};
                        count <= count + CW'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seqmul_arbiter.sv
// Self-checking bench for seqmul_arbiter: directed vector table, randomized
// transactions against an arbitration/product model, and multi-cycle corners
// (throughput, held response, reset abort).
module tb_seqmul_arbiter;

    localparam int WIDTH = 16;
    localparam int LATENCY = WIDTH + 1;
    localparam int PERIOD = WIDTH + 3;

    logic               clk;
    logic               reset;
    logic               req0_valid;
    logic [WIDTH-1:0]   req0_a;
    logic [WIDTH-1:0]   req0_b;
    logic               req0_ready;
    logic               req1_valid;
    logic [WIDTH-1:0]   req1_a;
    logic [WIDTH-1:0]   req1_b;
    logic               req1_ready;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [2*WIDTH-1:0] rsp_product;
    logic               busy;

    int errors = 0;
    int checks = 0;
    int cycleCount = 0;
    logic lastServed;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [15:0] a0;
        logic [15:0] b0;
        logic [15:0] a1;
        logic [15:0] b1;
        int          hold;
        logic        expId;
        logic [31:0] expProd;
    } vec_t;

    vec_t vecs[5];

    seqmul_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .reset(reset),
        .req0_valid(req0_valid),
        .req0_a(req0_a),
        .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_a(req1_a),
        .req1_b(req1_b),
        .req1_ready(req1_ready),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_product(rsp_product),
        .busy(busy)
    );

    // Free-running clock and cycle counter used for throughput measurement.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic resetDut();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        lastServed = 1'b1;
    endtask

    // One complete transaction: request, fixed-latency wait, optional response
    // stall, handshake, and a look at the IDLE cycle that follows.
    task automatic applyStimulus(input logic v0, input logic v1,
                                 input logic [15:0] a0, input logic [15:0] b0,
                                 input logic [15:0] a1, input logic [15:0] b1,
                                 input int hold, input logic expId,
                                 input logic [31:0] expProd, input string tag);
        int n;
        bit seen;
        bit leak;
        bit unstable;
        @(negedge clk);
        req0_valid = v0;
        req1_valid = v1;
        req0_a = a0;
        req0_b = b0;
        req1_a = a1;
        req1_b = b1;
        rsp_ready = (hold == 0);
        #1;
        checkOutput({tag, " req0_ready"}, req0_ready, expId == 1'b0);
        checkOutput({tag, " req1_ready"}, req1_ready, expId == 1'b1);
        @(posedge clk);
        #1;
        req0_a = 16'($urandom);
        req0_b = 16'($urandom);
        req1_a = 16'($urandom);
        req1_b = 16'($urandom);
        n = 0;
        seen = 0;
        leak = 0;
        while (!seen && n < 3 * LATENCY) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (req0_ready || req1_ready) leak = 1;
            if (rsp_valid) seen = 1;
        end
        checkOutput({tag, " latency"}, n, LATENCY);
        checkOutput({tag, " ready while busy"}, leak, 0);
        checkOutput({tag, " rsp_id"}, rsp_id, expId);
        checkOutput({tag, " rsp_product"}, rsp_product, expProd);
        if (hold > 0) begin
            unstable = 0;
            repeat (hold) begin
                @(posedge clk);
                @(negedge clk);
                if (rsp_valid !== 1'b1 || rsp_product !== expProd || rsp_id !== expId ||
                    req0_ready || req1_ready)
                    unstable = 1;
            end
            checkOutput({tag, " held response"}, unstable, 0);
            rsp_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " rsp_valid after handshake"}, rsp_valid, 0);
        checkOutput({tag, " busy after handshake"}, busy, 0);
        checkOutput({tag, " ready after handshake"}, req0_ready | req1_ready, v0 | v1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    // Reference arbitration: single requester wins, otherwise the one not
    // served last.
    function automatic logic refGrant(input logic v0, input logic v1, input logic last);
        if (v0 && v1) return ~last;
        return v1;
    endfunction

    initial begin
        int accId[3];
        int accCycle[3];
        int found;
        int budget;
        bit bothReady;
        logic v0;
        logic v1;
        logic [15:0] a0;
        logic [15:0] b0;
        logic [15:0] a1;
        logic [15:0] b1;
        logic id;
        logic [31:0] prod;
        int pattern;

        vecs[0] = '{1'b1, 1'b0, 16'd3, 16'd5, 16'd0, 16'd0, 0, 1'b0, 32'h0000000F};
        vecs[1] = '{1'b0, 1'b1, 16'd0, 16'd0, 16'hFFFF, 16'hFFFF, 1, 1'b1, 32'hFFFE0001};
        vecs[2] = '{1'b1, 1'b1, 16'h0000, 16'h1234, 16'd7, 16'd9, 5, 1'b0, 32'h00000000};
        vecs[3] = '{1'b1, 1'b1, 16'd11, 16'd13, 16'h8000, 16'h0002, 2, 1'b1, 32'h00010000};
        vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 16'h0001, 16'd0, 16'd0, 0, 1'b0, 32'h0000FFFF};

        reset = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = 16'd1;
        req0_b = 16'd1;
        req1_a = 16'd1;
        req1_b = 16'd1;
        rsp_ready = 1'b0;
        #1;
        checkOutput("reset ready0", req0_ready, 0);
        checkOutput("reset ready1", req1_ready, 0);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset rsp_valid", rsp_valid, 0);
        checkOutput("reset rsp_product", rsp_product, 0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resetDut();

        $display("[TB] directed vector table");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].v0, vecs[i].v1, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
                          vecs[i].hold, vecs[i].expId, vecs[i].expProd, $sformatf("vec%0d", i));
        end
        lastServed = 1'b0;

        $display("[TB] randomized transactions");
        for (int i = 0; i < 20; i++) begin
            pattern = $urandom_range(1, 3);
            v0 = pattern[0];
            v1 = pattern[1];
            a0 = 16'($urandom);
            b0 = 16'($urandom);
            a1 = 16'($urandom);
            b1 = 16'($urandom);
            id = refGrant(v0, v1, lastServed);
            prod = id ? 32'(a1) * 32'(b1) : 32'(a0) * 32'(b0);
            lastServed = id;
            applyStimulus(v0, v1, a0, b0, a1, b1, $urandom_range(0, 3), id, prod,
                          $sformatf("rand%0d", i));
        end

        $display("[TB] back-to-back throughput with both requesters valid");
        resetDut();
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_a = 16'd2;
        req0_b = 16'd3;
        req1_a = 16'd4;
        req1_b = 16'd5;
        rsp_ready = 1'b1;
        found = 0;
        budget = 0;
        bothReady = 0;
        while (found < 3 && budget < 100) begin
            #1;
            if (req0_ready && req1_ready) bothReady = 1;
            if (req0_ready || req1_ready) begin
                accId[found] = req1_ready ? 1 : 0;
                accCycle[found] = cycleCount;
                found++;
            end
            @(negedge clk);
            budget++;
        end
        checkOutput("throughput accepts seen", found, 3);
        checkOutput("throughput both ready", bothReady, 0);
        if (found == 3) begin
            checkOutput("grant order 0", accId[0], 0);
            checkOutput("grant order 1", accId[1], 1);
            checkOutput("grant order 2", accId[2], 0);
            checkOutput("accept spacing 0-1", accCycle[1] - accCycle[0], PERIOD);
            checkOutput("accept spacing 1-2", accCycle[2] - accCycle[1], PERIOD);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rsp_ready = 1'b0;

        $display("[TB] reset abort during iterations");
        resetDut();
        @(negedge clk);
        req1_valid = 1'b1;
        req1_a = 16'hABCD;
        req1_b = 16'h1357;
        #1;
        checkOutput("abort setup ready1", req1_ready, 1);
        @(posedge clk);
        repeat (7) @(posedge clk);
        @(negedge clk);
        checkOutput("abort busy before", busy, 1);
        checkOutput("abort rsp_id before", rsp_id, 1);
        reset = 1'b0;
        #1;
        checkOutput("abort busy", busy, 0);
        checkOutput("abort rsp_valid", rsp_valid, 0);
        checkOutput("abort rsp_id", rsp_id, 0);
        checkOutput("abort rsp_product", rsp_product, 0);
        checkOutput("abort ready1", req1_ready, 0);
        @(negedge clk);
        reset = 1'b1;
        lastServed = 1'b1;
        req1_valid = 1'b0;
        applyStimulus(1'b1, 1'b0, 16'h1234, 16'h0000, 16'd0, 16'd0, 1, 1'b0, 32'h0, "after abort");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
